fetch_stage: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Holds the architectural fetch PC and issues one-at-a-time requests to the instruction cache.
- Presents fetched instructions to decode through the IFID registers, and honours the decode stall (IDIF_stall) and the execute branch redirect (EXIF_branch / EXIF_target).
- Squashes any in-flight fetch on redirect.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage and the I-cache.
interface fetch_stage_if;
    logic        ic_req_valid;
    logic [63:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;

    modport master (
        output ic_req_valid,
        output ic_req_addr,
        input  ic_req_ready,
        input  ic_resp_valid,
        input  ic_resp_data
    );

    modport slave (
        input  ic_req_valid,
        input  ic_req_addr,
        output ic_req_ready,
        output ic_resp_valid,
        output ic_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding I-cache request, IFID pipeline registers,
// decode-stall hold buffer and execute-stage redirect with in-flight squash.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IDIF_stall,
    input  logic                 EXIF_branch,
    input  logic [63:0]          EXIF_target,
    fetch_stage_if.master        ic,
    output logic [31:0]          IFID_instreg,
    output logic [63:0]          IFID_npc,
    output logic                 IFID_ready,
    output logic                 icachenotstall
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [63:0] hold_pc_q, hold_pc_d;
    logic [31:0] instreg_q, instreg_d;
    logic [63:0] npc_q, npc_d;
    logic        ready_q, ready_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instreg_d    = instreg_q;
        npc_d        = npc_q;
        ready_d      = ready_q;

        // Decode is draining IFID: show a bubble unless something is delivered below.
        if (!IDIF_stall) begin
            instreg_d = NOP_INSTR;
            ready_d   = 1'b0;
        end

        unique case (state_q)
            StReq: begin
                if (ic.ic_req_ready) state_d = StWait;
            end
            StWait: begin
                if (ic.ic_resp_valid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = StReq;
                    end else if (IDIF_stall) begin
                        hold_instr_d = ic.ic_resp_data;
                        hold_pc_d    = pc_q;
                        state_d      = StHold;
                    end else begin
                        instreg_d = ic.ic_resp_data;
                        npc_d     = pc_q;
                        ready_d   = 1'b1;
                        pc_d      = pc_q + 64'd4;
                        state_d   = StReq;
                    end
                end
            end
            StHold: begin
                if (!IDIF_stall) begin
                    instreg_d = hold_instr_q;
                    npc_d     = hold_pc_q;
                    ready_d   = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    state_d   = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // Redirect overrides everything decided above.
        if (EXIF_branch) begin
            pc_d         = EXIF_target;
            instreg_d    = NOP_INSTR;
            npc_d        = npc_q;
            ready_d      = 1'b0;
            hold_instr_d = 32'h0;
            hold_pc_d    = 64'h0;
            unique case (state_q)
                StReq: begin
                    if (ic.ic_req_ready) begin
                        squash_d = 1'b1;
                        state_d  = StWait;
                    end else begin
                        squash_d = squash_q;
                        state_d  = StReq;
                    end
                end
                StWait: begin
                    if (ic.ic_resp_valid) begin
                        squash_d = 1'b0;
                        state_d  = StReq;
                    end else begin
                        squash_d = 1'b1;
                        state_d  = StWait;
                    end
                end
                default: begin
                    squash_d = squash_q;
                    state_d  = StReq;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            squash_q     <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 64'h0;
            instreg_q    <= NOP_INSTR;
            npc_q        <= 64'h0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            squash_q     <= squash_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instreg_q    <= instreg_d;
            npc_q        <= npc_d;
            ready_q      <= ready_d;
        end
    end

    assign ic.ic_req_valid = (state_q == StReq);
    assign ic.ic_req_addr  = pc_q;
    assign IFID_instreg    = instreg_q;
    assign IFID_npc        = npc_q;
    assign IFID_ready      = ready_q;
    assign icachenotstall  = ready_q;

endmodule
